// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - raw button input and debounced level/strobe bundle
interface key_debounce_if;
    logic key_n;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output key_n,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  key_n,
        output key_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser and four-state debouncer for an active-low button
// Long-press strobe present only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int LONG_CYCLES     = 100,
    parameter int CNT_W           = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    key_debounce_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= 2**CNT_W ||
        LONG_CYCLES < 1 || LONG_CYCLES >= 2**CNT_W) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYCLES/LONG_CYCLES out of range for CNT_W");
    end

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] dcnt;
    logic             key_level;
    logic             press_pulse;
    logic             release_pulse;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(LONG_CYCLES);
    logic [CNT_W-1:0] hcnt;
    logic             long_pulse;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            s1            <= 1'b1;
            s2            <= 1'b1;
            dcnt          <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            hcnt          <= '0;
            long_pulse    <= 1'b0;
`endif
        end else begin
            s1            <= bus.key_n;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            // hcnt parks at LONG_CYCLES, so the L_LAST match can occur only once per press
            long_pulse <= 1'b0;
            if ((state == HELD || state == RELEASE_CHK) && hcnt != L_MAX)
                hcnt <= hcnt + ONE;
            if (state == HELD && hcnt == L_LAST)
                long_pulse <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (!s2) begin
                        state <= PRESS_CHK;
                        dcnt  <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (s2) begin
                        state <= IDLE;
                    end else if (dcnt == D_LAST) begin
                        state       <= HELD;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                        hcnt        <= '0;
`endif
                    end else begin
                        dcnt <= dcnt + ONE;
                    end
                end
                HELD: begin
                    if (s2) begin
                        state <= RELEASE_CHK;
                        dcnt  <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!s2) begin
                        state <= HELD;
                    end else if (dcnt == D_LAST) begin
                        state         <= IDLE;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        dcnt <= dcnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.key_level     = key_level;
    assign bus.press_pulse   = press_pulse;
    assign bus.release_pulse = release_pulse;
`ifdef KEY_LONG_PRESS_EN
    assign bus.long_pulse    = long_pulse;
`else
    assign bus.long_pulse    = 1'b0;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed and randomized checks of key_debounce against a run-length model
module tb_key_debounce;
    localparam int D  = 20;
    localparam int L  = 100;
    localparam int D1 = 1;
    localparam int L1 = 2;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    key_debounce_if bus ();
    key_debounce_if bus1 ();

    key_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    key_debounce #(.DEBOUNCE_CYCLES(D1), .LONG_CYCLES(L1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Reference: a change of level is accepted once D+1 consecutive synchronised
    // samples disagree with it; the long strobe belongs to the L-th edge after a press,
    // and only if the sample before that edge was still "pressed".
    bit m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0, m_prev_high = 1'b0;
    bit m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;
    int m_run = 0, m_held = 0;

    always @(posedge clk) begin : model
        bit smp;
        smp = m_s2;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_prev_high = 1'b0;
            m_run = 0; m_held = 0;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = bus.key_n;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
            if (!m_lvl) begin
                m_run = smp ? 0 : m_run + 1;
                if (m_run == D + 1) begin
                    m_lvl = 1'b1; m_press = 1'b1; m_run = 0; m_held = 0; m_prev_high = 1'b0;
                end
            end else begin
                if (m_held < L + 1) m_held++;
                if (LONG_EN && m_held == L && !m_prev_high) m_long = 1'b1;
                m_run = smp ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_lvl = 1'b0; m_rel = 1'b1; m_run = 0;
                end
                m_prev_high = smp;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; bus.key_n = 1'b1; bus1.key_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        bus.key_n = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (bus.key_level !== 1'b1) begin
            failures++; $display("FAIL reset_pre_level got=%b want=1", bus.key_level);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.key_level, bus.press_pulse, bus.release_pulse, bus.long_pulse} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b%b%b%b want=0000", i,
                         bus.key_level, bus.press_pulse, bus.release_pulse, bus.long_pulse);
            end
        end
        rst_n = 1'b1; bus.key_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_clean_press();
        do_reset();
        for (int e = 0; e < 60; e++) begin
            bus.key_n = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.press_pulse !== (e == D + 2)) begin
                failures++; $display("FAIL clean_press_pulse edge=%0d got=%b want=%b", e, bus.press_pulse, (e == D + 2));
            end
            checks++;
            if (bus.key_level !== (e >= D + 2)) begin
                failures++; $display("FAIL clean_press_level edge=%0d got=%b want=%b", e, bus.key_level, (e >= D + 2));
            end
        end
    endtask

    task automatic test_press_bounce();
        logic k;
        do_reset();
        for (int e = 0; e < 70; e++) begin
            k = (e < 5) ? 1'b0 : (e < 8) ? 1'b1 : (e < 15) ? 1'b0 : (e < 17) ? 1'b1 : 1'b0;
            bus.key_n = k;
            @(negedge clk);
            checks++;
            if (bus.press_pulse !== (e == 39)) begin
                failures++; $display("FAIL bounce_press_pulse edge=%0d got=%b want=%b", e, bus.press_pulse, (e == 39));
            end
            checks++;
            if (bus.key_level !== (e >= 39)) begin
                failures++; $display("FAIL bounce_press_level edge=%0d got=%b want=%b", e, bus.key_level, (e >= 39));
            end
        end
    endtask

    task automatic test_release_bounce();
        logic k;
        do_reset();
        bus.key_n = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (bus.key_level !== 1'b1) begin
            failures++; $display("FAIL release_setup_level got=%b want=1", bus.key_level);
        end
        for (int e = 0; e < 60; e++) begin
            k = (e < 10) ? 1'b1 : (e < 12) ? 1'b0 : 1'b1;
            bus.key_n = k;
            @(negedge clk);
            checks++;
            if (bus.key_level !== (e < 34)) begin
                failures++; $display("FAIL release_level edge=%0d got=%b want=%b", e, bus.key_level, (e < 34));
            end
            checks++;
            if (bus.release_pulse !== (e == 34)) begin
                failures++; $display("FAIL release_pulse edge=%0d got=%b want=%b", e, bus.release_pulse, (e == 34));
            end
            checks++;
            if (bus.press_pulse !== 1'b0 || bus.long_pulse !== 1'b0) begin
                failures++; $display("FAIL release_other_pulse edge=%0d got=%b%b want=00", e, bus.press_pulse, bus.long_pulse);
            end
        end
    endtask

    task automatic test_long_press();
        do_reset();
        for (int e = 0; e < 300; e++) begin
            bus.key_n = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.press_pulse !== (e == D + 2)) begin
                failures++; $display("FAIL long_press_pulse edge=%0d got=%b want=%b", e, bus.press_pulse, (e == D + 2));
            end
            checks++;
            if (bus.long_pulse !== (LONG_EN && e == D + 2 + L)) begin
                failures++; $display("FAIL long_pulse edge=%0d got=%b want=%b", e, bus.long_pulse, (LONG_EN && e == D + 2 + L));
            end
        end
        for (int e = 0; e < 40; e++) begin
            bus.key_n = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.release_pulse !== (e == D + 2)) begin
                failures++; $display("FAIL long_release_pulse edge=%0d got=%b want=%b", e, bus.release_pulse, (e == D + 2));
            end
        end
    endtask

    task automatic test_reset_mid_check();
        logic any_out;
        do_reset();
        for (int e = 0; e < 60; e++) begin
            bus.key_n = 1'b0;
            rst_n = !(e >= 10 && e <= 12);
            @(negedge clk);
            any_out = bus.key_level | bus.press_pulse | bus.release_pulse | bus.long_pulse;
            if (e >= 10 && e <= 12) begin
                checks++;
                if (any_out !== 1'b0) begin
                    failures++; $display("FAIL midreset_outputs edge=%0d got=%b want=0", e, any_out);
                end
            end
            checks++;
            if (bus.press_pulse !== (e == 35)) begin
                failures++; $display("FAIL midreset_press edge=%0d got=%b want=%b", e, bus.press_pulse, (e == 35));
            end
            checks++;
            if (bus.key_level !== (e >= 35)) begin
                failures++; $display("FAIL midreset_level edge=%0d got=%b want=%b", e, bus.key_level, (e >= 35));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_degenerate();
        do_reset();
        for (int e = 0; e < 10; e++) begin
            bus1.key_n = 1'b0;
            @(negedge clk);
            checks++;
            if (bus1.press_pulse !== (e == 3) || bus1.key_level !== (e >= 3)) begin
                failures++; $display("FAIL d1_press edge=%0d got=%b%b want=%b%b", e,
                                     bus1.press_pulse, bus1.key_level, (e == 3), (e >= 3));
            end
            checks++;
            if (bus1.long_pulse !== (LONG_EN && e == 3 + L1)) begin
                failures++; $display("FAIL d1_long edge=%0d got=%b want=%b", e, bus1.long_pulse, (LONG_EN && e == 3 + L1));
            end
        end
        for (int e = 0; e < 10; e++) begin
            bus1.key_n = 1'b1;
            @(negedge clk);
            checks++;
            if (bus1.release_pulse !== (e == 3) || bus1.key_level !== (e < 3)) begin
                failures++; $display("FAIL d1_release edge=%0d got=%b%b want=%b%b", e,
                                     bus1.release_pulse, bus1.key_level, (e == 3), (e < 3));
            end
        end
    endtask

    task automatic test_random();
        int  len;
        int  cyc;
        logic k;
        do_reset();
        cyc = 0;
        for (int seg = 0; seg < 80; seg++) begin
            k   = 1'($urandom_range(0, 1));
            len = (seg % 8 == 7) ? int'($urandom_range(100, 160)) : int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) begin
                bus.key_n = k;
                rst_n = ($urandom_range(0, 599) != 0);
                @(negedge clk);
                cyc++;
                checks++;
                if (bus.key_level !== m_lvl) begin
                    failures++; $display("FAIL rnd_level cyc=%0d got=%b want=%b", cyc, bus.key_level, m_lvl);
                end
                checks++;
                if (bus.press_pulse !== m_press) begin
                    failures++; $display("FAIL rnd_press cyc=%0d got=%b want=%b", cyc, bus.press_pulse, m_press);
                end
                checks++;
                if (bus.release_pulse !== m_rel) begin
                    failures++; $display("FAIL rnd_release cyc=%0d got=%b want=%b", cyc, bus.release_pulse, m_rel);
                end
                checks++;
                if (bus.long_pulse !== m_long) begin
                    failures++; $display("FAIL rnd_long cyc=%0d got=%b want=%b", cyc, bus.long_pulse, m_long);
                end
                checks++;
                if (32'(bus.press_pulse) + 32'(bus.release_pulse) + 32'(bus.long_pulse) > 1) begin
                    failures++; $display("FAIL rnd_exclusive cyc=%0d got=%b%b%b want=at most one", cyc,
                                         bus.press_pulse, bus.release_pulse, bus.long_pulse);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.key_n  = 1'b1;
        bus1.key_n = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_long_press();
        test_reset_mid_check();
        test_degenerate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
# key_debounce

Upstream input stage for the LED blink logic. It synchronises a raw, bouncing active-low push-button into the `clk` domain and debounces it with a four-state FSM. It emits a clean level plus single-cycle press, release and (optionally) long-press strobes. The LED blink counter consumes `press_pulse` as its blink enable toggle and `long_pulse` as its rate-select toggle.

## Interface
- `DEBOUNCE_CYCLES`, default 20: number of consecutive stable synchronised samples required to accept a press or release; legal range 1..2^CNT_W-1.
- `LONG_CYCLES`, default 100: number of held cycles, counted from the accepted press, before `long_pulse` fires; legal range 1..2^CNT_W-1.
- `CNT_W`, default 16: width of the debounce and hold counters.

- `clk`, input, 1: clock. Reset `rst_n` is synchronous and active-low.
- `rst_n`, input, 1: synchronous active-low reset.
- `key_n`, input, 1: raw button, asynchronous to `clk`, 0 = pressed.
- `key_level`, output, 1: debounced level, 1 = pressed; registered.
- `press_pulse`, output, 1: one-cycle strobe on an accepted press; registered.
- `release_pulse`, output, 1: one-cycle strobe on an accepted release; registered.
- `long_pulse`, output, 1: one-cycle strobe on a long press; registered; constant 0 when the feature is compiled out.

## Operation
- **Synchroniser:** 2 flops, `s1` then `s2`, both reset to 1 (released). The FSM uses `s2` only.
- **`IDLE`** (`key_level` = 0):
  - `s2` = 0: go to `PRESS_CHK` with `dcnt` = 0.
- **`PRESS_CHK`:**
  - `s2` = 1: return to `IDLE`. This is a bounce; no output.
  - `s2` = 0 and `dcnt` = DEBOUNCE_CYCLES-1: go to `HELD`. Set `key_level` = 1, pulse `press_pulse`, clear `hcnt`.
  - Otherwise: `dcnt`++.
- **`HELD`:**
  - `s2` = 1: go to `RELEASE_CHK` with `dcnt` = 0.
- **`RELEASE_CHK`:**
  - `s2` = 0: return to `HELD`. This is a bounce; no output, and `key_level` stays 1.
  - `s2` = 1 and `dcnt` = DEBOUNCE_CYCLES-1: go to `IDLE`. Set `key_level` = 0, pulse `release_pulse`.
  - Otherwise: `dcnt`++.
- **Hold counter `hcnt`:**
  - Increments every cycle in `HELD` and `RELEASE_CHK`, saturating at LONG_CYCLES.
  - Not cleared by a release bounce.
- **Long press:** `long_pulse` fires for one cycle when `hcnt` = LONG_CYCLES-1 and the state is `HELD`. At most one `long_pulse` per accepted press.
- **Pulse exclusivity:** the three pulses are mutually exclusive in any cycle. Each is high for exactly 1 cycle.
- **Counter width:** counters never wrap. `dcnt` is bounded by DEBOUNCE_CYCLES-1; `hcnt` saturates.

## Timing
- **Reset:**
  - Outputs after reset: `key_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `long_pulse` = 0.
  - Internal state after reset: state `IDLE`, `dcnt` = 0, `hcnt` = 0, `s1` = `s2` = 1.
- **Reset mid-operation:** reset overrides everything, including an in-flight pulse, and no pulse is emitted for the aborted press. If `key_n` is still low after reset, the press is re-detected with full latency.
- **Press latency:** with `key_n` low at rising edge 0 and stable, `press_pulse` and `key_level` go high after edge DEBOUNCE_CYCLES+2. That is 2 synchroniser edges plus the `IDLE` to `PRESS_CHK` edge plus DEBOUNCE_CYCLES-1 count edges.
- **Release latency:** symmetric. `release_pulse` goes high and `key_level` goes low after edge DEBOUNCE_CYCLES+2, counted from the first stable-high sample.
- **Long-press latency:** `long_pulse` fires after edge DEBOUNCE_CYCLES+2+LONG_CYCLES, counted from the press sample, provided the key stays in `HELD`.
- **Bounce filtering:** any low or high run shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- **Degenerate parameter:** DEBOUNCE_CYCLES = 1 accepts on the first check cycle, giving latency 3.
- **Long-press window during release check:** if `hcnt` reaches LONG_CYCLES-1 while in `RELEASE_CHK`, no `long_pulse` is emitted in that cycle. If `s2` returns to 0, the FSM re-enters `HELD`, but `long_pulse` is no longer emitted for that press.

## Configuration
- Macro: `KEY_LONG_PRESS_EN`.
- **Defined:** `hcnt` and the long-press logic are present, as described above.
- **Undefined:** `hcnt` is removed, `LONG_CYCLES` is ignored, and `long_pulse` is tied to 0. All other behaviour and latencies are identical.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 20, LONG_CYCLES = 100, and `KEY_LONG_PRESS_EN` defined.

1. **Clean press:** `key_n` low from edge 0 for 60 cycles -> `press_pulse` high for exactly the cycle after edge 22, and `key_level` = 1 from edge 22.
2. **Press bounce:** `key_n` low 5 cycles, high 3, low 7, high 2, then low stable from edge 17 -> no pulse until after edge 39; then exactly one `press_pulse`.
3. **Release with bounce:** from `HELD`, `key_n` high 10 cycles, low 2, then high stable -> `key_level` stays 1 through the glitch; a single `release_pulse` fires 22 edges after the final rising sample; `key_level` = 0.
4. **Long press:** `key_n` low from edge 0 for 300 cycles -> `press_pulse` at edge 22, a single `long_pulse` at edge 122, no further `long_pulse`; release then gives `release_pulse`. Rebuild without `KEY_LONG_PRESS_EN` -> `long_pulse` stays 0 throughout.
5. **Reset mid-check:** `key_n` low from edge 0, `rst_n` low at edges 10–12 -> all outputs 0, no pulse before edge 35, `press_pulse` after edge 35 (22 edges after `rst_n` is sampled high at edge 13).
